// File: rtl/imem_pkg.sv
// Shared types, constants and address check for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 4;

    // True when addr is word aligned and falls inside a depth_words-word memory.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_words);
        logic [33:0] limit;
        limit = 34'(WORD_BYTES) * 34'(depth_words);
        return (addr[1:0] == 2'b00) && (34'(addr) < limit);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage: synchronous write, combinational read, contents not reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]   waddr,
    input  logic [WORD_BYTES*8-1:0]          wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0]   raddr,
    output logic [WORD_BYTES*8-1:0]          rdata
);

    logic [WORD_BYTES*8-1:0] mem [DEPTH_WORDS];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch, waits WAIT_STATES cycles,
// then pulses resp_valid with the word (or an error/NOP). Program-load port
// writes only while idle. Define IMEM_STATS_EN to add fetch/error counters.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q;
    logic [31:0]        rd_addr;
    logic [31:0]        rd_data;
    logic               rd_ok;
    logic               accept;
    logic               capture;
    logic               load_we;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and strobe decode.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        load_we    = 1'b0;
        rd_addr    = addr_q;
        case (state)
            IDLE: begin
                req_ready = !load_en;
                load_we   = load_en && addr_ok(load_addr, DEPTH_WORDS);
                rd_addr   = req_addr;
                if (req_valid && !load_en) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_ok      = addr_ok(rd_addr, DEPTH_WORDS);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // Request address latch, wait counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            addr_q     <= '0;
            resp_instr <= NOP_INSTR;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                resp_err   <= !rd_ok;
                resp_instr <= rd_ok ? rd_data : NOP_INSTR;
            end
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (load_we),
        .waddr (load_addr[AW+1:2]),
        .wdata (load_data),
        .raddr (rd_addr[AW+1:2]),
        .rdata (rd_data)
    );

`ifdef IMEM_STATS_EN
    // Accepted-fetch and saturating error-response counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (capture && !rd_ok && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule
